// File: rtl/v_fifo_stream_pkg.sv
// rtl/v_fifo_stream_pkg.sv - shared width helpers and parameter legality check for v_fifo_stream
package v_fifo_stream_pkg;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Lane addressing never wraps inside a beat only if depth is a multiple of both beat sizes.
   function automatic bit params_ok(input int w, input int r, input int depth);
      return (w > 0) && (r > 0) && (depth > 0) && (depth % w == 0) && (depth % r == 0);
   endfunction

endpackage

// File: rtl/v_fifo_ram.sv
// rtl/v_fifo_ram.sv - element storage: W-lane synchronous write, R-lane combinational read
module v_fifo_ram #(
   parameter int NBits = 8,
   parameter int W     = 4,
   parameter int R     = 2,
   parameter int D     = 16,
   parameter int PW    = 4
) (
   input  logic                     clk_in,
   input  logic                     wr_en,
   input  logic [PW-1:0]            wr_addr,
   input  logic [W-1:0][NBits-1:0]  wr_data,
   input  logic [PW-1:0]            rd_addr,
   output logic [R-1:0][NBits-1:0]  rd_data
);

   logic [NBits-1:0] mem [D];

   // Beat base addresses are multiples of the beat size, so base + lane stays below D.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         for (int i = 0; i < W; i++) begin
            mem[wr_addr + PW'(i)] <= wr_data[i];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < R; i++) begin
         rd_data[i] = mem[rd_addr + PW'(i)];
      end
   end

endmodule

// File: rtl/v_fifo_stream.sv
// rtl/v_fifo_stream.sv - width-converting show-ahead FIFO with hold/rewind replay mark
module v_fifo_stream
   import v_fifo_stream_pkg::*;
#(
   parameter int NBits            = 8,
   parameter int ElementsPerWrite = 4,
   parameter int ElementsPerRead  = 2,
   parameter int DepthElems       = 16
) (
   input  logic                                       clk_in,
   input  logic                                       rst_in,
   input  logic                                       wr_valid,
   output logic                                       wr_ready,
   input  logic [ElementsPerWrite-1:0][NBits-1:0]     wr_data,
   input  logic                                       rd_ready,
   output logic                                       rd_valid,
   output logic [ElementsPerRead-1:0][NBits-1:0]      rd_data,
   input  logic                                       hold,
   input  logic                                       rewind,
   output logic [cnt_width(DepthElems)-1:0]           avail,
   output logic [cnt_width(DepthElems)-1:0]           used,
   output logic                                       err_ovf,
   output logic                                       err_udf
);

   localparam int W  = ElementsPerWrite;
   localparam int R  = ElementsPerRead;
   localparam int D  = DepthElems;
   localparam int CW = cnt_width(D);
   localparam int PW = ptr_width(D);

   generate
      if (!params_ok(W, R, D)) begin : g_bad_params
         $error("v_fifo_stream: DepthElems must be a positive multiple of both beat sizes");
      end
   endgenerate

   logic [PW-1:0] wr_ptr, rd_ptr, mark, rd_ptr_nxt;
   logic [CW-1:0] avail_nxt, wr_add;
   logic          wr_fire, rd_fire, do_rewind;

   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int n);
      logic [PW:0] s;
      s = {1'b0, p} + (PW+1)'(n);
      if (s >= (PW+1)'(D)) s = s - (PW+1)'(D);
      return s[PW-1:0];
   endfunction

   assign wr_ready  = (used <= CW'(D - W));
   assign rd_valid  = (avail >= CW'(R));
   assign wr_fire   = wr_valid && wr_ready;
   assign rd_fire   = rd_valid && rd_ready;
   assign do_rewind = rewind && hold;
   assign wr_add    = wr_fire ? CW'(W) : '0;

   // A rewind replays everything from the mark, so any read in that cycle is dropped.
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      avail_nxt  = avail + wr_add;
      if (do_rewind) begin
         rd_ptr_nxt = mark;
         avail_nxt  = used + wr_add;
      end else if (rd_fire) begin
         rd_ptr_nxt = adv(rd_ptr, R);
         avail_nxt  = avail + wr_add - CW'(R);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mark    <= '0;
         avail   <= '0;
         used    <= '0;
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (wr_fire) wr_ptr <= adv(wr_ptr, W);
         rd_ptr <= rd_ptr_nxt;
         avail  <= avail_nxt;
         // Without hold the mark follows the read pointer, releasing read space at once.
         if (!hold) begin
            mark <= rd_ptr_nxt;
            used <= avail_nxt;
         end else begin
            used <= used + wr_add;
         end
         if (wr_valid && !wr_ready) err_ovf <= 1'b1;
         if (rd_ready && !rd_valid && !rewind) err_udf <= 1'b1;
      end
   end

   v_fifo_ram #(
      .NBits (NBits),
      .W     (W),
      .R     (R),
      .D     (D),
      .PW    (PW)
   ) u_ram (
      .clk_in  (clk_in),
      .wr_en   (wr_fire && !rst_in),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_v_fifo_stream.sv
// tb/tb_v_fifo_stream.sv - self-checking bench for v_fifo_stream with a queue-based reference model
module tb_v_fifo_stream;

   localparam int NB = 8;
   localparam int W  = 4;
   localparam int R  = 2;
   localparam int D  = 16;

   logic                 clk = 1'b0;
   logic                 rst, wr_valid, wr_ready, rd_ready, rd_valid, hold, rewind;
   logic                 err_ovf, err_udf;
   logic [W-1:0][NB-1:0] wr_data;
   logic [R-1:0][NB-1:0] rd_data;
   logic [4:0]           avail, used;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: q holds every element from the mark onward; rd_off counts those read since.
   int q[$];
   int rd_off = 0;
   bit m_ovf = 1'b0;
   bit m_udf = 1'b0;

   always #5 clk = ~clk;

   v_fifo_stream #(
      .NBits(NB), .ElementsPerWrite(W), .ElementsPerRead(R), .DepthElems(D)
   ) dut (
      .clk_in(clk), .rst_in(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .hold(hold), .rewind(rewind),
      .avail(avail), .used(used), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   function automatic int e_avail(); return q.size() - rd_off; endfunction
   function automatic int e_used();  return q.size(); endfunction
   function automatic bit e_rvld();  return e_avail() >= R; endfunction
   function automatic bit e_wrdy();  return (D - e_used()) >= W; endfunction
   function automatic logic [NB-1:0] e_lane(input int i); return NB'(q[rd_off + i]); endfunction

   function automatic logic [W*NB-1:0] beat(input int base);
      logic [W*NB-1:0] v;
      for (int i = 0; i < W; i++) v[i*NB +: NB] = NB'(base + i);
      return v;
   endfunction

   task automatic tick(input bit wv, input logic [W*NB-1:0] wd, input bit rr,
                       input bit h, input bit rw, input bit rs);
      bit wrdy, rvld;
      wrdy = e_wrdy();
      rvld = e_rvld();
      rst = rs; wr_valid = wv; wr_data = wd; rd_ready = rr; hold = h; rewind = rw;
      if (rs) begin
         q.delete(); rd_off = 0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (wv && !wrdy) m_ovf = 1'b1;
         if (rr && !rvld && !rw) m_udf = 1'b1;
         if (rw && h) rd_off = 0;
         else if (rr && rvld) rd_off += R;
         if (wv && wrdy) for (int i = 0; i < W; i++) q.push_back(int'(wd[i*NB +: NB]));
         if (!h) begin
            repeat (rd_off) void'(q.pop_front());
            rd_off = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      tick(0, '0, 0, 0, 0, 1);
      n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_checks++; if (avail !== 5'd0) begin n_errors++; $display("FAIL reset_avail: got %0d want 0", avail); end
      n_checks++; if (used !== 5'd0) begin n_errors++; $display("FAIL reset_used: got %0d want 0", used); end
      n_checks++; if ({err_ovf, err_udf} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b want 00", {err_ovf, err_udf}); end
   endtask

   task automatic test_fill_drain();
      tick(0, '0, 0, 0, 0, 1);
      for (int b = 0; b < 4; b++) tick(1, beat(4*b), 0, 0, 0, 0);
      n_checks++; if (used !== 5'd16) begin n_errors++; $display("FAIL fill_used: got %0d want 16", used); end
      n_checks++; if (wr_ready !== 1'b0) begin n_errors++; $display("FAIL fill_wr_ready: got %b want 0", wr_ready); end
      for (int k = 0; k < 8; k++) begin
         n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL drain_valid[%0d]: got %b want 1", k, rd_valid); end
         n_checks++; if (rd_data !== {NB'(2*k+1), NB'(2*k)}) begin n_errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, rd_data, {NB'(2*k+1), NB'(2*k)}); end
         tick(0, '0, 1, 0, 0, 0);
      end
      n_checks++; if (avail !== 5'd0) begin n_errors++; $display("FAIL drain_avail: got %0d want 0", avail); end
      n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL drain_rd_valid: got %b want 0", rd_valid); end
   endtask

   task automatic test_overflow();
      tick(0, '0, 0, 0, 0, 1);
      for (int b = 0; b < 4; b++) tick(1, beat(8'h10 + 4*b), 0, 0, 0, 0);
      tick(1, beat(8'hA0), 0, 0, 0, 0);
      n_checks++; if (err_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", err_ovf); end
      n_checks++; if (used !== 5'd16) begin n_errors++; $display("FAIL ovf_used: got %0d want 16", used); end
      n_checks++; if (rd_data !== {8'h11, 8'h10}) begin n_errors++; $display("FAIL ovf_data0: got %h want 1110", rd_data); end
      tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (rd_data !== {8'h13, 8'h12}) begin n_errors++; $display("FAIL ovf_data1: got %h want 1312", rd_data); end
   endtask

   task automatic test_rewind();
      tick(0, '0, 0, 0, 0, 1);
      tick(1, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 0, 1, 0, 0);
      tick(0, '0, 1, 1, 0, 0);
      tick(0, '0, 1, 1, 0, 0);
      n_checks++; if (used !== 5'd4) begin n_errors++; $display("FAIL hold_used: got %0d want 4", used); end
      n_checks++; if (avail !== 5'd0) begin n_errors++; $display("FAIL hold_avail: got %0d want 0", avail); end
      tick(0, '0, 1, 1, 1, 0);
      n_checks++; if (rd_data !== {8'hB2, 8'hA1}) begin n_errors++; $display("FAIL rewind_data: got %h want b2a1", rd_data); end
      n_checks++; if (avail !== 5'd4) begin n_errors++; $display("FAIL rewind_avail: got %0d want 4", avail); end
      n_checks++; if (used !== 5'd4) begin n_errors++; $display("FAIL rewind_used: got %0d want 4", used); end
      n_checks++; if (err_udf !== 1'b0) begin n_errors++; $display("FAIL rewind_udf: got %b want 0", err_udf); end
      tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (used !== 5'd2) begin n_errors++; $display("FAIL release_used1: got %0d want 2", used); end
      tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (used !== 5'd0) begin n_errors++; $display("FAIL release_used2: got %0d want 0", used); end
   endtask

   task automatic test_wrap();
      tick(0, '0, 0, 0, 0, 1);
      for (int b = 0; b < 3; b++) tick(1, beat(8'h30 + 4*b), 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (avail !== 5'd2) begin n_errors++; $display("FAIL wrap_avail2: got %0d want 2", avail); end
      tick(1, beat(8'h3C), 1, 0, 0, 0);
      n_checks++; if (avail !== 5'd4) begin n_errors++; $display("FAIL wrap_simul_avail: got %0d want 4", avail); end
      tick(1, beat(8'h40), 0, 0, 0, 0);
      n_checks++; if (used !== 5'd8) begin n_errors++; $display("FAIL wrap_used: got %0d want 8", used); end
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (rd_data !== {NB'(8'h3D + 2*k), NB'(8'h3C + 2*k)}) begin n_errors++; $display("FAIL wrap_data[%0d]: got %h want %h", k, rd_data, {NB'(8'h3D + 2*k), NB'(8'h3C + 2*k)}); end
         tick(0, '0, 1, 0, 0, 0);
      end
   endtask

   task automatic test_reset_mid();
      tick(0, '0, 0, 0, 0, 1);
      tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (err_udf !== 1'b1) begin n_errors++; $display("FAIL udf_flag: got %b want 1", err_udf); end
      for (int b = 0; b < 3; b++) tick(1, beat(8'h50 + 4*b), 0, 0, 0, 0);
      tick(0, '0, 1, 0, 0, 0);
      n_checks++; if (avail !== 5'd10) begin n_errors++; $display("FAIL mid_avail10: got %0d want 10", avail); end
      tick(1, beat(8'h70), 1, 0, 0, 1);
      n_checks++; if (avail !== 5'd0) begin n_errors++; $display("FAIL mid_rst_avail: got %0d want 0", avail); end
      n_checks++; if (used !== 5'd0) begin n_errors++; $display("FAIL mid_rst_used: got %0d want 0", used); end
      n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_rd_valid: got %b want 0", rd_valid); end
      n_checks++; if ({err_ovf, err_udf} !== 2'b00) begin n_errors++; $display("FAIL mid_rst_flags: got %b want 00", {err_ovf, err_udf}); end
   endtask

   task automatic test_random();
      bit h = 1'b0;
      tick(0, '0, 0, 0, 0, 1);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(15) == 0) h = !h;
         tick($urandom_range(9) < 6, W*NB'($urandom), $urandom_range(9) < 6, h,
              $urandom_range(7) == 0, $urandom_range(299) == 0);
         n_checks++; if (avail !== 5'(e_avail())) begin n_errors++; $display("FAIL rnd_avail[%0d]: got %0d want %0d", n, avail, e_avail()); end
         n_checks++; if (used !== 5'(e_used())) begin n_errors++; $display("FAIL rnd_used[%0d]: got %0d want %0d", n, used, e_used()); end
         n_checks++; if (wr_ready !== e_wrdy()) begin n_errors++; $display("FAIL rnd_wr_ready[%0d]: got %b want %b", n, wr_ready, e_wrdy()); end
         n_checks++; if (rd_valid !== e_rvld()) begin n_errors++; $display("FAIL rnd_rd_valid[%0d]: got %b want %b", n, rd_valid, e_rvld()); end
         n_checks++; if ({err_ovf, err_udf} !== {m_ovf, m_udf}) begin n_errors++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, {err_ovf, err_udf}, {m_ovf, m_udf}); end
         if (e_rvld()) begin
            for (int i = 0; i < R; i++) begin
               n_checks++; if (rd_data[i] !== e_lane(i)) begin n_errors++; $display("FAIL rnd_data[%0d][%0d]: got %h want %h", n, i, rd_data[i], e_lane(i)); end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; hold = 1'b0; rewind = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_rewind();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
